// File: rtl/mux_rr_reg_if.sv
// mux_rr_reg_if: handshake and data bundle for mux_rr_reg.
//   in_data   : CHANNELS*WIDTH packed channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (driven by the mux)
//   out_data  : registered selected word
//   out_valid : out_data holds an untaken word
//   out_ready : downstream accept
//   out_ch    : source channel of out_data
// slave modport is the mux side, master modport is the source/sink side.
interface mux_rr_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_ch;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel multiplexer into a single registered output entry.
// Manual mode offers the channel given by sel; auto mode scans channels
// round-robin, staying on a channel for up to dwell+1 transfers and skipping
// channels with no valid word one per cycle.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   mode    : 0 = manual select, 1 = auto round-robin scan
//   sel     : manual channel select (values >= CHANNELS select nothing)
//   dwell   : auto mode transfers per visit minus one
//   cur_sel : channel offered this cycle
//   bus     : mux_rr_reg_if slave (input channels, registered output)
module mux_rr_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   cur_sel,
  mux_rr_reg_if.slave        bus
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_next;
  logic [DWELL_W-1:0] cnt;
  logic               can_accept;
  logic               valid_cur;
  logic               xfer;
  logic [WIDTH-1:0]   sel_data;

  // Channel selection. Only an in-range cur_sel matches a loop index, so an
  // out-of-range manual select leaves in_ready all zero and valid_cur low.
  always_comb begin
    cur_sel      = mode ? ptr : sel;
    can_accept   = !bus.out_valid || bus.out_ready;
    valid_cur    = 1'b0;
    sel_data     = '0;
    bus.in_ready = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cur_sel == SEL_W'(k)) begin
        valid_cur       = bus.in_valid[k];
        sel_data        = bus.in_data[k*WIDTH +: WIDTH];
        bus.in_ready[k] = can_accept;
      end
    end
    xfer     = valid_cur && can_accept;
    ptr_next = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
  end

  // Single-entry output register: load on transfer (also covers the
  // simultaneous pop+load case), otherwise drain on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_ch    <= cur_sel;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Scan pointer and per-visit counter. ptr only moves in auto mode, so it
  // always stays below CHANNELS. The >= compare lets a dwell lowered below
  // the running count end the visit on the next transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (!mode) begin
      cnt <= '0;
    end else if (!valid_cur) begin
      ptr <= ptr_next;
      cnt <= '0;
    end else if (xfer) begin
      if (cnt >= dwell) begin
        ptr <= ptr_next;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Testbench for mux_rr_reg: table of vectors for a 4-channel instance with a
// scoreboard queue for output words, hand sequences for async reset, and a
// 3-channel instance for skip/wrap behaviour.
module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-channel instance, SEL_W=3 so that out-of-range selects are reachable
  logic       mode4;
  logic [2:0] sel4;
  logic [3:0] dwell4;
  logic [2:0] cur4;
  mux_rr_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(3)) b4 ();
  mux_rr_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(3), .DWELL_W(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .dwell(dwell4),
    .cur_sel(cur4), .bus(b4)
  );

  // 3-channel instance
  logic       mode3;
  logic [1:0] sel3;
  logic [3:0] dwell3;
  logic [1:0] cur3;
  mux_rr_reg_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) b3 ();
  mux_rr_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL_W(4)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .dwell(dwell3),
    .cur_sel(cur3), .bus(b3)
  );

  typedef struct {
    logic        mode;
    logic [2:0]  sel;
    logic [3:0]  dwell;
    logic [3:0]  iv;
    logic        ordy;
    logic [2:0]  cur;
    logic [3:0]  rdy;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] ch;
  } exp_t;

  exp_t q[$];
  vec_t tbl[31];

  function automatic vec_t mk(input logic m, input logic [2:0] s, input logic [3:0] d,
                              input logic [3:0] iv, input logic o,
                              input logic [2:0] c, input logic [3:0] r);
    vec_t v;
    v.mode = m; v.sel = s; v.dwell = d; v.iv = iv; v.ordy = o;
    v.cur = c; v.rdy = r; v.data = '0;
    return v;
  endfunction

  function automatic logic [31:0] fill(input int idx);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(idx*19 + k*65 + 5);
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one vector, check combinational outputs and the registered word
  // against the scoreboard, then advance one clock.
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    mode4 = v.mode; sel4 = v.sel; dwell4 = v.dwell;
    b4.in_valid = v.iv; b4.in_data = v.data; b4.out_ready = v.ordy;
    #1;
    check({nm, "/cur_sel"}, 32'(cur4), 32'(v.cur));
    check({nm, "/in_ready"}, 32'(b4.in_ready), 32'(v.rdy));
    check({nm, "/out_valid"}, 32'(b4.out_valid), 32'(q.size() != 0));
    if (q.size() != 0 && v.ordy) begin
      e = q.pop_front();
      check({nm, "/out_data"}, 32'(b4.out_data), 32'(e.d));
      check({nm, "/out_ch"}, 32'(b4.out_ch), 32'(e.ch));
    end
    if ((v.rdy & v.iv) != 4'b0000)
      q.push_back('{d: v.data[int'(v.cur)*8 +: 8], ch: v.cur});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           mode sel   dwell  iv       ordy cur   rdy
    // manual: load, 3-cycle stall, back-to-back reload, pop
    tbl[0]  = mk(0, 3'd2, 4'd0, 4'b0100, 1, 3'd2, 4'b0100);
    tbl[1]  = mk(0, 3'd2, 4'd0, 4'b0100, 0, 3'd2, 4'b0000);
    tbl[2]  = mk(0, 3'd2, 4'd0, 4'b0100, 0, 3'd2, 4'b0000);
    tbl[3]  = mk(0, 3'd2, 4'd0, 4'b0100, 0, 3'd2, 4'b0000);
    tbl[4]  = mk(0, 3'd2, 4'd0, 4'b0100, 1, 3'd2, 4'b0100);
    tbl[5]  = mk(0, 3'd1, 4'd0, 4'b0010, 1, 3'd1, 4'b0010);
    tbl[6]  = mk(0, 3'd3, 4'd0, 4'b0000, 1, 3'd3, 4'b1000);
    tbl[7]  = mk(0, 3'd0, 4'd0, 4'b0001, 1, 3'd0, 4'b0001);
    tbl[8]  = mk(0, 3'd0, 4'd0, 4'b0000, 1, 3'd0, 4'b0001);
    // auto, dwell=1, all valid: channels 0,0,1,1,2,2,3,3,0
    tbl[9]  = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd0, 4'b0001);
    tbl[10] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd0, 4'b0001);
    tbl[11] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd1, 4'b0010);
    tbl[12] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd1, 4'b0010);
    tbl[13] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd2, 4'b0100);
    tbl[14] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd2, 4'b0100);
    tbl[15] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd3, 4'b1000);
    tbl[16] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd3, 4'b1000);
    tbl[17] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd0, 4'b0001);
    // backpressure holds the pointer, then second transfer ends the visit
    tbl[18] = mk(1, 3'd0, 4'd1, 4'b1111, 0, 3'd0, 4'b0000);
    tbl[19] = mk(1, 3'd0, 4'd1, 4'b1111, 1, 3'd0, 4'b0001);
    // dwell=0, only ch2 valid: skip empty channels one per cycle, wrap 3->0
    tbl[20] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd1, 4'b0010);
    tbl[21] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd2, 4'b0100);
    tbl[22] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd3, 4'b1000);
    tbl[23] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd0, 4'b0001);
    tbl[24] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd1, 4'b0010);
    tbl[25] = mk(1, 3'd0, 4'd0, 4'b0100, 1, 3'd2, 4'b0100);
    // manual out-of-range select, then resume auto at the held pointer
    tbl[26] = mk(0, 3'd5, 4'd0, 4'b1111, 1, 3'd5, 4'b0000);
    tbl[27] = mk(0, 3'd5, 4'd0, 4'b1111, 1, 3'd5, 4'b0000);
    tbl[28] = mk(1, 3'd5, 4'd0, 4'b1111, 1, 3'd3, 4'b1000);
    tbl[29] = mk(1, 3'd5, 4'd0, 4'b1111, 1, 3'd0, 4'b0001);
    tbl[30] = mk(0, 3'd7, 4'd0, 4'b0000, 1, 3'd7, 4'b0000);
    for (int i = 0; i < 31; i++) tbl[i].data = fill(i);
    tbl[0].data[23:16] = 8'hA5;

    // idle inputs; 3-channel instance parked on an invalid manual select
    mode4 = 1'b1; sel4 = '0; dwell4 = '0;
    b4.in_valid = '0; b4.in_data = '0; b4.out_ready = 1'b0;
    mode3 = 1'b0; sel3 = 2'd3; dwell3 = '0;
    b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;

    #2;
    check("reset/out_valid", 32'(b4.out_valid), 32'd0);
    check("reset/out_data", 32'(b4.out_data), 32'd0);
    check("reset/out_ch", 32'(b4.out_ch), 32'd0);
    check("reset/ptr", 32'(cur4), 32'd0);
    mode4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 31; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // async reset between edges discards the held word and zeroes ptr
    begin
      vec_t v;
      v = mk(0, 3'd2, 4'd0, 4'b0100, 0, 3'd2, 4'b0100);
      v.data = fill(40);
      apply(v, "rst_load");
      mode4 = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b0;
      #1;
      check("rst_pre/cur_sel", 32'(cur4), 32'd1);
      check("rst_pre/in_ready", 32'(b4.in_ready), 32'd0);
      check("rst_pre/out_valid", 32'(b4.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async/out_valid", 32'(b4.out_valid), 32'd0);
      check("rst_async/out_data", 32'(b4.out_data), 32'd0);
      check("rst_async/out_ch", 32'(b4.out_ch), 32'd0);
      check("rst_async/cur_sel", 32'(cur4), 32'd0);
      check("rst_async/in_ready", 32'(b4.in_ready), 32'b0001);
      q.delete();
      mode4 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      v = mk(0, 3'd2, 4'd0, 4'b0100, 1, 3'd2, 4'b0100);
      v.data = fill(41);
      apply(v, "rst_after1");
      v = mk(0, 3'd2, 4'd0, 4'b0000, 1, 3'd2, 4'b0100);
      v.data = fill(42);
      apply(v, "rst_after2");
    end

    // 3-channel instance: invalid select, then auto skip/wrap with only ch2 valid
    b3.in_data = {8'hC3, 8'h22, 8'h11};
    b3.in_valid = 3'b111;
    #1;
    check("c3_sel3/in_ready", 32'(b3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("c3_sel3/out_valid", 32'(b3.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mode3 = 1'b1; dwell3 = 4'd0; b3.in_valid = 3'b100; b3.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("c3_%0d/cur_sel", i), 32'(cur3), 32'(i % 3));
      check($sformatf("c3_%0d/in_ready", i), 32'(b3.in_ready), 32'(1 << (i % 3)));
      check($sformatf("c3_%0d/out_valid", i), 32'(b3.out_valid), 32'(i > 0 && i % 3 == 0));
      if (i > 0 && i % 3 == 0) begin
        check($sformatf("c3_%0d/out_ch", i), 32'(b3.out_ch), 32'd2);
        check($sformatf("c3_%0d/out_data", i), 32'(b3.out_data), 32'hC3);
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, input channel count (2..16, need not be a power of two).
REQ-003 Parameter SEL_W, default 2, select/pointer width, SHALL satisfy 2^SEL_W >= CHANNELS.
REQ-004 Parameter DWELL_W, default 4, width of the auto-scan dwell limit.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 mode  in  1  0 = manual select, 1 = auto round-robin scan.
REQ-008 sel  in  SEL_W  manual channel select.
REQ-009 dwell  in  DWELL_W  auto mode: max transfers per channel visit minus one.
REQ-010 in_data  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-011 in_valid  in  CHANNELS  per-channel valid.
REQ-012 in_ready  out  CHANNELS  per-channel ready, combinational.
REQ-013 out_data  out  WIDTH  registered selected data.
REQ-014 out_valid  out  1  out_data holds an untaken word.
REQ-015 out_ready  in  1  downstream accept.
REQ-016 out_ch  out  SEL_W  source channel of out_data.
REQ-017 cur_sel  out  SEL_W  channel offered this cycle (manual: sel; auto: scan pointer).

Function
REQ-018 Output stage SHALL be a single registered entry; can_accept = !out_valid | out_ready.
REQ-019 in_ready[k] SHALL be 1 only when k == cur_sel, cur_sel < CHANNELS, and can_accept; all other bits 0.
REQ-020 Transfer SHALL occur on a cycle with in_valid[cur_sel] & in_ready[cur_sel]; next edge loads out_data = channel cur_sel data, out_ch = cur_sel, out_valid = 1 (latency one cycle).
REQ-021 Without a new transfer, out_valid & out_ready SHALL clear out_valid; out_data/out_ch hold last value.
REQ-022 Simultaneous output pop and input transfer SHALL load the new word with out_valid staying 1 (full throughput, one word per cycle).
REQ-023 out_valid high and out_ready low SHALL hold out_data, out_ch, out_valid stable.
REQ-024 Manual mode: cur_sel = sel; sel >= CHANNELS SHALL select nothing (in_ready all 0, no transfer).
REQ-025 Auto mode SHALL keep scan pointer ptr and visit counter cnt (DWELL_W bits); cur_sel = ptr.
REQ-026 Auto: on a transfer with cnt == dwell, ptr advances, cnt <- 0; on a transfer with cnt < dwell, cnt increments.
REQ-027 Auto: if in_valid[ptr] == 0 on a cycle, ptr SHALL advance and cnt <- 0 (skip empty channel, one channel per cycle).
REQ-028 Auto: if in_valid[ptr] == 1 but can_accept == 0, ptr and cnt SHALL hold (no skip under backpressure).
REQ-029 ptr advance SHALL wrap from CHANNELS-1 to 0.
REQ-030 In manual mode cnt SHALL be held at 0 and ptr SHALL hold its value; switching to auto resumes at held ptr with cnt = 0.
REQ-031 dwell changes SHALL take effect on the next compare; dwell = 0 means one transfer per visit.
REQ-032 mode change SHALL not disturb a word already in the output register.

Reset
REQ-033 rst high SHALL immediately force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, cnt = 0, independent of clk.
REQ-034 Reset asserted mid-transfer SHALL discard the in-flight word; in_ready follows from out_valid = 0 while in manual mode with valid sel, all 0 in auto only per REQ-019.
REQ-035 First transfer after rst deassert SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-036 Manual, CHANNELS=4, sel=2, in_valid=4'b0100, ch2=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2; in_ready=4'b0100.
REQ-037 Manual, out_ready=0 for 3 cycles after load -> out_data held, in_ready=0; out_ready=1 with new word -> back-to-back load, out_valid stays 1.
REQ-038 Auto, dwell=1, all in_valid=1, out_ready=1 -> out_ch sequence 0,0,1,1,2,2,3,3,0.
REQ-039 Auto, CHANNELS=3, dwell=0, in_valid=3'b100 -> ptr skips 0,1 in one cycle each, out_ch=2 repeatedly, wrap 2->0 observed.
REQ-040 Manual sel=5 with CHANNELS=4 -> in_ready=0, no transfer; rst pulse mid-burst (async, between edges) -> out_valid=0, ptr=0 immediately.
